// File: rtl/async_fifo_wr_arbiter_if.sv
// Write-port bundle between packet sources, the arbiter and the async FIFO write side.
// The arbiter takes the master modport; sources and the FIFO model take the slave modport.
interface async_fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          wren;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          gnt_valid;
  logic [ID_WIDTH-1:0]           gnt_id;

  modport master (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, wren, wdata, gnt_valid, gnt_id
  );

  modport slave (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, wren, wdata, gnt_valid, gnt_id
  );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one async FIFO write port among NUM_REQ sources.
// A grant ends on the last beat of a packet or after MAX_BURST accepted beats.
module async_fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  async_fifo_wr_arbiter_if.master bus
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_gnt_id;
  logic             r_gnt_valid;
  logic [CNT_W-1:0] r_beat_cnt;

  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [ID_W-1:0]       w_winner;
  logic                  w_granted;
  logic                  w_wren;
  logic                  w_burst_end;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [ID_W-1:0]       w_rr_next;
  logic [NUM_REQ-1:0]    w_ready;

  // Mux of the granted source's beat.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt_id == ID_W'(i)) begin
        w_sel_valid = bus.req_valid[i];
        w_sel_last  = bus.req_last[i];
        w_sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) w_winner = ID_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (ID_W'(i) >= r_rr_ptr)) w_winner = ID_W'(i);
    end
  end

  // Reset gates the port directly so nothing is written while wrst_n is low.
  always_comb begin
    w_granted = (r_state == ST_GRANT) && wrst_n;
    w_wren    = w_granted && w_sel_valid && !bus.wfull;
    w_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_granted && !bus.wfull && (r_gnt_id == ID_W'(i))) w_ready[i] = 1'b1;
    end
    w_cnt_inc   = r_beat_cnt + CNT_W'(1);
    w_burst_end = w_sel_last || (w_cnt_inc == CNT_W'(MAX_BURST));
    w_rr_next   = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);
  end

  assign bus.req_ready = w_ready;
  assign bus.wren      = w_wren;
  assign bus.wdata     = w_sel_data;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_id    = r_gnt_id;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            r_state     <= ST_GRANT;
            r_gnt_id    <= w_winner;
            r_gnt_valid <= 1'b1;
            r_beat_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          if (w_wren) begin
            if (w_burst_end) begin
              r_state     <= ST_IDLE;
              r_gnt_valid <= 1'b0;
              r_rr_ptr    <= w_rr_next;
              r_beat_cnt  <= '0;
            end else begin
              r_beat_cnt  <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: a per-cycle vector table plus hand-written
// sequences for burst capping and reset in the middle of a packet.
module tb_async_fifo_wr_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;
  localparam int unsigned IW = 2;

  logic wclk = 1'b0;
  logic wrst_n;
  always #5 wclk = ~wclk;

  async_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  async_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic [3:0]  v;
    logic [3:0]  l;
    logic        full;
    logic [7:0]  tag;
    logic        e_wren;
    logic [3:0]  e_rdy;
    logic        e_gv;
    logic [1:0]  e_gid;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, input logic [3:0] v, input logic [3:0] l,
                     input logic full, input logic [7:0] tag, input logic e_wren,
                     input logic [3:0] e_rdy, input logic e_gv, input logic [1:0] e_gid,
                     input logic [31:0] e_wd);
    vec_t r;
    r.rst_n = rst_n; r.v = v; r.l = l; r.full = full; r.tag = tag;
    r.e_wren = e_wren; r.e_rdy = e_rdy; r.e_gv = e_gv; r.e_gid = e_gid; r.e_wd = e_wd;
    tbl.push_back(r);
  endtask

  // Source i presents {i, 16'h0, tag} so the granted index is visible in wdata.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic full,
                       input logic [7:0] tag);
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = (32'(i) << 24) | 32'(tag);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.wfull     = full;
  endtask

  logic [31:0] s_data[NR][8];
  logic        s_last[NR][8];
  int          s_len[NR];
  int          s_pos[NR];
  logic [3:0]  s_v;

  task automatic drive_src();
    logic [NR*DW-1:0] d;
    logic [3:0] l;
    for (int i = 0; i < NR; i++) begin
      s_v[i] = (s_pos[i] < s_len[i]);
      d[i*DW +: DW] = s_v[i] ? s_data[i][s_pos[i]] : 32'h0;
      l[i] = s_v[i] ? s_last[i][s_pos[i]] : 1'b0;
    end
    bus.req_valid = s_v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.wfull     = 1'b0;
  endtask

  task automatic load(input int src, input int n, input logic [31:0] base);
    for (int k = 0; k < 8; k++) begin
      s_data[src][k] = base + 32'(k);
      s_last[src][k] = (k == n - 1);
    end
    s_len[src] = n;
    s_pos[src] = 0;
  endtask

  function automatic logic busy();
    logic b = 1'b0;
    for (int i = 0; i < NR; i++) if (s_pos[i] < s_len[i]) b = 1'b1;
    return b;
  endfunction

  logic [31:0] got[$];
  logic [31:0] exp5[7];
  int writes;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin s_len[i] = 0; s_pos[i] = 0; end
    // reset, src2 packet, round robin from rr=3, backpressure on src1
    add(0, 4'hF, 4'hF, 0, 8'h00, 0, 4'h0, 0, 2'd0, 32'h0);
    add(0, 4'hF, 4'hF, 0, 8'h00, 0, 4'h0, 0, 2'd0, 32'h0);
    add(0, 4'hF, 4'hF, 0, 8'h00, 0, 4'h0, 0, 2'd0, 32'h0);
    add(1, 4'h4, 4'h0, 0, 8'h0A, 0, 4'h0, 0, 2'd0, 32'h0);
    add(1, 4'h4, 4'h0, 0, 8'h0A, 1, 4'h4, 1, 2'd2, 32'h0200000A);
    add(1, 4'h4, 4'h0, 0, 8'h0B, 1, 4'h4, 1, 2'd2, 32'h0200000B);
    add(1, 4'h4, 4'h4, 0, 8'h0C, 1, 4'h4, 1, 2'd2, 32'h0200000C);
    add(1, 4'hF, 4'hF, 0, 8'h10, 0, 4'h0, 0, 2'd2, 32'h0);
    add(1, 4'hF, 4'hF, 0, 8'h10, 1, 4'h8, 1, 2'd3, 32'h03000010);
    add(1, 4'hF, 4'hF, 0, 8'h10, 0, 4'h0, 0, 2'd3, 32'h0);
    add(1, 4'hF, 4'hF, 0, 8'h10, 1, 4'h1, 1, 2'd0, 32'h00000010);
    add(1, 4'hF, 4'hF, 0, 8'h10, 0, 4'h0, 0, 2'd0, 32'h0);
    add(1, 4'hF, 4'hF, 0, 8'h10, 1, 4'h2, 1, 2'd1, 32'h01000010);
    add(1, 4'hF, 4'hF, 0, 8'h10, 0, 4'h0, 0, 2'd1, 32'h0);
    add(1, 4'hF, 4'hF, 0, 8'h10, 1, 4'h4, 1, 2'd2, 32'h02000010);
    add(1, 4'hF, 4'hF, 0, 8'h10, 0, 4'h0, 0, 2'd2, 32'h0);
    add(1, 4'hF, 4'hF, 0, 8'h10, 1, 4'h8, 1, 2'd3, 32'h03000010);
    add(1, 4'h2, 4'h0, 0, 8'h21, 0, 4'h0, 0, 2'd3, 32'h0);
    add(1, 4'h2, 4'h0, 0, 8'h21, 1, 4'h2, 1, 2'd1, 32'h01000021);
    add(1, 4'h2, 4'h0, 1, 8'h22, 0, 4'h0, 1, 2'd1, 32'h0);
    add(1, 4'h2, 4'h0, 1, 8'h22, 0, 4'h0, 1, 2'd1, 32'h0);
    add(1, 4'h3, 4'h0, 1, 8'h22, 0, 4'h0, 1, 2'd1, 32'h0);
    add(1, 4'h2, 4'h0, 1, 8'h22, 0, 4'h0, 1, 2'd1, 32'h0);
    add(1, 4'h2, 4'h0, 1, 8'h22, 0, 4'h0, 1, 2'd1, 32'h0);
    add(1, 4'h0, 4'h0, 0, 8'h22, 0, 4'h2, 1, 2'd1, 32'h0);
    add(1, 4'h2, 4'h0, 0, 8'h22, 1, 4'h2, 1, 2'd1, 32'h01000022);
    add(1, 4'h2, 4'h2, 0, 8'h23, 1, 4'h2, 1, 2'd1, 32'h01000023);
    add(1, 4'h0, 4'h0, 0, 8'h00, 0, 4'h0, 0, 2'd1, 32'h0);
    add(1, 4'h0, 4'h0, 0, 8'h00, 0, 4'h0, 0, 2'd1, 32'h0);

    wrst_n = 1'b0;
    drive(4'hF, 4'hF, 1'b0, 8'h00);
    repeat (2) @(posedge wclk);

    foreach (tbl[i]) begin
      @(negedge wclk);
      wrst_n = tbl[i].rst_n;
      drive(tbl[i].v, tbl[i].l, tbl[i].full, tbl[i].tag);
      #1;
      chk($sformatf("r%0d.wren", i), 32'(bus.wren), 32'(tbl[i].e_wren));
      chk($sformatf("r%0d.ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("r%0d.gnt_valid", i), 32'(bus.gnt_valid), 32'(tbl[i].e_gv));
      chk($sformatf("r%0d.gnt_id", i), 32'(bus.gnt_id), 32'(tbl[i].e_gid));
      if (tbl[i].e_wren) chk($sformatf("r%0d.wdata", i), bus.wdata, tbl[i].e_wd);
    end

    // Burst cap: 6-beat src0 packet split at 4 beats, src1 slips in between.
    load(0, 6, 32'h00000051);
    load(1, 1, 32'h01000061);
    exp5 = '{32'h00000051, 32'h00000052, 32'h00000053, 32'h00000054,
             32'h01000061, 32'h00000055, 32'h00000056};
    got.delete();
    for (int c = 0; c < 60 && busy(); c++) begin
      @(negedge wclk);
      drive_src();
      #1;
      chk("t5.wren_vs_ready", 32'(bus.wren), 32'(|(s_v & bus.req_ready)));
      if (bus.wren) got.push_back(bus.wdata);
      for (int i = 0; i < NR; i++) if (s_v[i] && bus.req_ready[i]) s_pos[i]++;
    end
    chk("t5.done", 32'(busy()), 32'h0);
    chk("t5.count", 32'(got.size()), 32'd7);
    for (int k = 0; k < 7; k++)
      chk($sformatf("t5.beat%0d", k), (k < got.size()) ? got[k] : 32'hDEAD_DEAD, exp5[k]);

    // Reset after 2 of 5 src3 beats; the next grant restarts scanning from index 0.
    load(3, 5, 32'h03000071);
    writes = 0;
    for (int c = 0; c < 20 && writes < 2; c++) begin
      @(negedge wclk);
      drive_src();
      #1;
      if (bus.wren) begin
        chk($sformatf("t6.wdata%0d", writes), bus.wdata, s_data[3][s_pos[3]]);
        writes++;
      end
      for (int i = 0; i < NR; i++) if (s_v[i] && bus.req_ready[i]) s_pos[i]++;
    end
    chk("t6.writes_before_reset", 32'(writes), 32'd2);
    load(1, 1, 32'h01000081);
    @(negedge wclk);
    wrst_n = 1'b0;
    drive_src();
    #1;
    chk("t6.rst.wren", 32'(bus.wren), 32'h0);
    chk("t6.rst.ready", 32'(bus.req_ready), 32'h0);
    @(negedge wclk);
    wrst_n = 1'b1;
    drive_src();
    #1;
    chk("t6.idle.wren", 32'(bus.wren), 32'h0);
    chk("t6.idle.gnt_valid", 32'(bus.gnt_valid), 32'h0);
    chk("t6.idle.gnt_id", 32'(bus.gnt_id), 32'h0);
    @(negedge wclk);
    drive_src();
    #1;
    chk("t6.regrant.gnt_valid", 32'(bus.gnt_valid), 32'h1);
    chk("t6.regrant.gnt_id", 32'(bus.gnt_id), 32'h1);
    chk("t6.regrant.wren", 32'(bus.wren), 32'h1);
    chk("t6.regrant.wdata", bus.wdata, 32'h01000081);

    @(negedge wclk);
    drive(4'h0, 4'h0, 1'b0, 8'h00);
    repeat (3) @(negedge wclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
